// File: rtl/usb_tx_serializer_if.sv
// Word handoff from the TX packet controller into the serializer (valid/ready).
interface usb_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/usb_tx_serializer.sv
// USB TX serializer: double-buffered words shifted out LSB-first with optional bit stuffing.
// Latency: word accepted while idle is loaded one clock later; each bit lasts CLKS_PER_BIT clocks.
// Backpressure: tx_ready drops while the holding register is full; back-to-back words stream gap-free.
module usb_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_RUN    = 6
) (
    input  logic               clk,
    input  logic               n_rst,
    usb_tx_serializer_if.slave tx,
    input  logic               stuff_en,
    output logic               serial_out,
    output logic               bit_strobe,
    output logic               byte_done,
    output logic               busy
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int RW = $clog2(STUFF_RUN + 1);

    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(STUFF_RUN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [TW-1:0]         timer_q;
    logic [IW-1:0]         idx_q;
    logic [RW-1:0]         run_q;
    logic [RW-1:0]         run_d;
    logic [RW-1:0]         run_inc;
    logic                  cur_bit;
    logic                  last_bit;
    logic                  accept;
    logic                  load;
    logic                  advance;
    logic                  enter_stuff;
    logic                  last_done;

    assign tx.tx_ready = ~hold_full;
    assign accept      = tx.tx_valid & ~hold_full;
    assign cur_bit     = shift_q[idx_q];
    assign last_bit    = (idx_q == IDX_LAST);
    // Saturating so a long run with stuffing disabled cannot wrap back to a small count.
    assign run_inc     = !cur_bit ? '0 :
                         (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        load        = 1'b0;
        advance     = 1'b0;
        enter_stuff = 1'b0;
        last_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_strobe) begin
                    run_d = run_inc;
                    if (stuff_en && (run_inc == RUN_MAX)) begin
                        enter_stuff = 1'b1;
                        state_d     = STUFF;
                        run_d       = '0;
                        last_done   = last_bit;
                    end else if (!last_bit) begin
                        advance = 1'b1;
                    end else begin
                        last_done = 1'b1;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            run_d   = '0;
                        end
                    end
                end
            end
            STUFF: begin
                // byte_done for a word ending in a stuffed bit was already issued on entry.
                if (bit_strobe) begin
                    if (!last_bit) begin
                        advance = 1'b1;
                        state_d = SHIFT;
                    end else if (hold_full) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        bit_strobe = (state_q != IDLE) && (timer_q == TIMER_MAX);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_q     <= '0;
            hold_full  <= 1'b0;
            shift_q    <= '0;
            timer_q    <= '0;
            idx_q      <= '0;
            run_q      <= '0;
            serial_out <= 1'b1;
            byte_done  <= 1'b0;
        end else begin
            timer_q   <= (!busy || bit_strobe) ? '0 : timer_q + TW'(1);
            run_q     <= run_d;
            byte_done <= last_done;

            if (accept) begin
                hold_q    <= tx.tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                shift_q    <= hold_q;
                idx_q      <= '0;
                serial_out <= hold_q[0];
            end else if (advance) begin
                idx_q      <= idx_q + IW'(1);
                serial_out <= shift_q[idx_q + IW'(1)];
            end else if (enter_stuff) begin
                serial_out <= 1'b0;
            end else if (state_d == IDLE) begin
                serial_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboard bench: driver queues expected data bits on accept, line monitor applies stuffing rules.
module tb_usb_tx_serializer;
    localparam int DW  = 8;
    localparam int CPB = 8;
    localparam int SR  = 6;

    logic clk;
    logic n_rst;
    logic stuff_en;
    logic serial_out;
    logic bit_strobe;
    logic byte_done;
    logic busy;

    usb_tx_serializer_if #(.DATA_WIDTH(DW)) tx_if ();

    usb_tx_serializer #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STUFF_RUN   (SR)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx        (tx_if.slave),
        .stuff_en  (stuff_en),
        .serial_out(serial_out),
        .bit_strobe(bit_strobe),
        .byte_done (byte_done),
        .busy      (busy)
    );

    typedef struct packed {
        logic val;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   checks        = 0;
    int   errors        = 0;
    int   last_busy_len = 0;
    int   done_cnt      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_true(input string name, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got 0 required 1", name);
        end
    endtask

    // Line monitor: reference model of the bit stream seen on serial_out.
    int   bit_clks    = 0;
    int   run         = 0;
    int   busy_len    = 0;
    logic pend_stuff  = 1'b0;
    logic done_pend   = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (!n_rst) begin
            exp_q.delete();
            bit_clks   = 0;
            run        = 0;
            busy_len   = 0;
            pend_stuff = 1'b0;
            done_pend  = 1'b0;
        end else begin
            chk("byte_done", byte_done, done_pend);
            if (byte_done) done_cnt++;
            done_pend = 1'b0;
            if (!busy) begin
                if (busy_len != 0) begin
                    last_busy_len = busy_len;
                    chk("stuff_before_idle", pend_stuff, 0);
                end
                busy_len   = 0;
                bit_clks   = 0;
                run        = 0;
                pend_stuff = 1'b0;
                chk("idle_line", serial_out, 1);
                chk("idle_strobe", bit_strobe, 0);
            end else begin
                busy_len++;
                bit_clks++;
                if (bit_strobe) begin
                    chk("bit_len", bit_clks, CPB);
                    bit_clks = 0;
                    if (pend_stuff) begin
                        chk("stuff_bit", serial_out, 0);
                        pend_stuff = 1'b0;
                    end else begin
                        chk_true("bit_expected", exp_q.size() != 0);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("data_bit", serial_out, e.val);
                            run = e.val ? run + 1 : 0;
                            if (stuff_en && run >= SR) begin
                                pend_stuff = 1'b1;
                                run        = 0;
                            end
                            done_pend = e.last;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] w);
        int g;
        g = 0;
        tx_if.tx_data  = w;
        tx_if.tx_valid = 1'b1;
        while (!tx_if.tx_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk_true("send_timeout", g < 2000);
        if (g < 2000) begin
            for (int i = 0; i < DW; i++) exp_q.push_back('{val: w[i], last: (i == DW - 1)});
        end
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || !tx_if.tx_ready) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk_true("idle_timeout", g < 5000);
        @(negedge clk);
    endtask

    task automatic run_single(input logic [DW-1:0] w, input logic se, input int exp_len);
        wait_idle();
        stuff_en = se;
        send(w);
        chk("accept_busy", busy, 0);
        chk("accept_ready", tx_if.tx_ready, 0);
        @(negedge clk);
        chk("load_busy", busy, 1);
        chk("load_ready", tx_if.tx_ready, 1);
        chk("first_bit", serial_out, w[0]);
        wait_idle();
        chk("word_clocks", last_busy_len, exp_len);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [DW-1:0] w;
    int            gap;
    int            d0;

    initial begin
        n_rst          = 1'b1;
        stuff_en       = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_serial_out", serial_out, 1);
        chk("rst_tx_ready", tx_if.tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bit_strobe", bit_strobe, 0);
        chk("rst_byte_done", byte_done, 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        run_single(8'hA5, 1'b1, DW * CPB);
        run_single(8'hFF, 1'b0, DW * CPB);
        run_single(8'hFC, 1'b1, (DW + 1) * CPB);

        // Two all-ones words streamed: one stuffed bit in each word, run carried over.
        wait_idle();
        stuff_en = 1'b1;
        d0 = done_cnt;
        send(8'hFF);
        send(8'hFF);
        wait_idle();
        chk("b2b_clocks", last_busy_len, (2 * DW + 2) * CPB);
        chk("b2b_done_pulses", done_cnt - d0, 2);

        // Abort in the middle of bit 4 of 0xA5 with a second word waiting.
        wait_idle();
        send(8'hA5);
        send(8'h3C);
        repeat (26) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("abort_serial_out", serial_out, 1);
        chk("abort_tx_ready", tx_if.tx_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_bit_strobe", bit_strobe, 0);
        chk("abort_byte_done", byte_done, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (150) begin
            @(negedge clk);
            chk("post_abort_busy", busy, 0);
        end

        for (int p = 0; p < 6; p++) begin
            wait_idle();
            stuff_en = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < 10; k++) begin
                case ($urandom_range(0, 2))
                    0:       w = 8'hFF;
                    1:       w = DW'($urandom | $urandom);
                    default: w = DW'($urandom);
                endcase
                send(w);
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 120) : $urandom_range(0, 4);
                repeat (gap) @(negedge clk);
            end
        end

        wait_idle();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_tx_serializer.md
# usb_tx_serializer

Parametrised USB transmit serializer. It accepts parallel words over a valid/ready handshake and double-buffers them so back-to-back words stream with no gaps. Each word goes out LSB-first, one bit per CLKS_PER_BIT clocks, with optional USB bit stuffing. The block sits between the TX packet controller and the NRZI encoder in the USB TX path, and replaces the fixed 8-bit, always-shifting serializer.

## Interface
- DATA_WIDTH, 8: bits per word; must be at least 2.
- CLKS_PER_BIT, 8: clocks per serial bit period; must be at least 2.
- STUFF_RUN, 6: number of consecutive 1s that triggers an inserted 0.

- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_WIDTH  word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty; a word is accepted on an edge where tx_valid and tx_ready are both 1.
- stuff_en  input  1  enables bit stuffing; sampled at each bit boundary.
- serial_out  output  1  serial bit stream; idles at 1.
- bit_strobe  output  1  high during the last clock of every transmitted bit period, including stuffed bits.
- byte_done  output  1  one-clock pulse after the last data bit of a word completes.
- busy  output  1  high while any data bit or stuffed bit is on the line.

## Operation
- Storage: a one-entry holding register (hold_full) and a shift register. The shift register also keeps a bit index (0..DATA_WIDTH-1) and a ones-run counter (0..STUFF_RUN).
- tx_ready = !hold_full, driven from a register. Accepting a word sets hold_full.
- States:
  - IDLE: no bits pending. On an edge with hold_full=1: load the shift register from the holding register, clear hold_full, set serial_out = bit 0, clear timer and bit index, go to SHIFT.
  - SHIFT: serial_out holds the current data bit.
  - STUFF: serial_out = 0 for one bit period.
- Bit timer counts 0..CLKS_PER_BIT-1. bit_strobe = (state != IDLE) && timer == CLKS_PER_BIT-1.
- At each bit boundary (edge where bit_strobe=1) in SHIFT:
  - Run counter: if the bit just sent was 1, increment the run counter; otherwise clear it.
  - If stuff_en=1 and the run counter reaches STUFF_RUN: go to STUFF, clear the run counter. If this was the last data bit, also pulse byte_done.
  - Otherwise, if the bit index is below DATA_WIDTH-1: advance to the next bit.
  - Otherwise (last data bit): pulse byte_done. If hold_full=1, load the next word and stay in SHIFT. If hold_full=0, go to IDLE, set serial_out=1 and clear the run counter.
- At each bit boundary in STUFF:
  - If data bits remain in the current word: return to SHIFT with the next bit.
  - Otherwise, if hold_full=1: load the next word into SHIFT.
  - Otherwise: go to IDLE.
- The run counter carries across words while streaming is continuous.
- busy = (state != IDLE).
- There is never an accept/load conflict: a load only occurs when hold_full=1, and in that case tx_ready=0.

## Timing
- Reset values, asynchronous on n_rst=0: serial_out=1, tx_ready=1, bit_strobe=0, byte_done=0, busy=0, state=IDLE. Timer, bit index, run counter and hold_full are all 0.
- Reset mid-word aborts immediately. No partial bits are sent afterwards, and the holding register is discarded.
- Latency:
  - A word accepted at edge E0 while IDLE is loaded at E1. Its first bit appears on serial_out after E1. tx_ready returns to 1 after E1.
  - Each bit lasts exactly CLKS_PER_BIT clocks.
  - When the holding register is full at the final boundary, the next word starts at that boundary with zero idle cycles between words.
- byte_done is high for the single clock after the last data bit's boundary edge. If a stuffed bit follows, busy stays 1 until the stuffed bit's boundary.
- A word of DATA_WIDTH bits with k stuffed bits occupies (DATA_WIDTH+k)*CLKS_PER_BIT clocks.
- stuff_en changes take effect at the next bit boundary.

## Test plan
All scenarios use the default parameters (DATA_WIDTH=8, CLKS_PER_BIT=8, STUFF_RUN=6).
- Reset check: assert n_rst=0 asynchronously with no clock edge → serial_out=1, tx_ready=1, busy=0, bit_strobe=0, byte_done=0.
- Single word 0xA5, stuff_en=1 → serial_out sequence 1,0,1,0,0,1,0,1, each bit 8 clocks with 8 bit_strobes. One byte_done pulse, then serial_out returns to 1 and busy=0 after 64 clocks.
- Back-to-back 0xFF, 0xFF, stuff_en=1, second word presented while the first is shifting:
  - Line sequence: six 1s, 0, 1, 1 | 1, 1, 1, 1, 0, 1, 1, 1, 1 (18 bits, 144 clocks) with no gap between words.
  - byte_done pulses twice.
- Word 0xFF, stuff_en=0 → eight 1s, no stuffed bit, 64 clocks, busy falls right after the last bit.
- Word 0xFC, stuff_en=1, nothing following:
  - Line sequence: 0, 0, six 1s, then a stuffed 0.
  - byte_done pulses after bit 8; busy stays high 8 more clocks, then serial_out=1.
- Reset mid-word: drop n_rst during bit 4 of 0xA5 with a second word held → all outputs return to their reset values immediately. After release, serial_out stays 1 and the held word is never transmitted.
